// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor: one shared decimal digit cell, LSD first,
// signed-magnitude subtract via a second ten's-complement pass over z.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results hold their last values
// RUN   | one digit of x +/- y per edge, LSD first, digit enters z at MSD
// COMP  | negative difference: ten's complement of z, one digit per edge
// DONE  | result final; next edge pulses done, drops busy, returns to IDLE
module bcd_serial_addsub #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*N_DIGITS-1:0] x,
  input  logic [4*N_DIGITS-1:0] y,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] z,
  output logic                  c_out,
  output logic                  neg,
  output logic                  err
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(N_DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, x_d;
  logic [W-1:0]    y_q, y_d;
  logic [W-1:0]    z_q, z_d;
  logic            op_q, op_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            c_out_q, c_out_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;

  logic            bad_digit;
  logic [3:0]      cell_a, cell_b;
  logic [4:0]      cell_sum;
  logic            cell_carry;
  logic [3:0]      cell_digit;
  logic [W-1:0]    z_shift;
  logic            last_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Shared digit cell. In COMP the b input is zero and a is the nines
  // complement of the current z digit, so the same +6 correction applies.
  always_comb begin
    if (state_q == COMP) begin
      cell_a = 4'd9 - z_q[3:0];
      cell_b = 4'd0;
    end else begin
      cell_a = x_q[3:0];
      cell_b = op_q ? (4'd9 - y_q[3:0]) : y_q[3:0];
    end
    cell_sum   = {1'b0, cell_a} + {1'b0, cell_b} + {4'd0, carry_q};
    cell_carry = (cell_sum > 5'd9);
    cell_digit = cell_carry ? (cell_sum[3:0] + 4'd6) : cell_sum[3:0];
  end

  always_comb begin
    z_shift            = z_q >> 4;
    z_shift[W-1 -: 4]  = cell_digit;
    last_digit         = (cnt_q == CW'(1));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    c_out_d = c_out_q;
    neg_d   = neg_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          op_d    = op;
          z_d     = '0;
          c_out_d = 1'b0;
          neg_d   = 1'b0;
          carry_d = op;
          cnt_d   = CW'(N_DIGITS);
          busy_d  = 1'b1;
          err_d   = bad_digit;
          state_d = bad_digit ? DONE : RUN;
        end
      end

      RUN: begin
        x_d     = x_q >> 4;
        y_d     = y_q >> 4;
        z_d     = z_shift;
        carry_d = cell_carry;
        cnt_d   = cnt_q - CW'(1);
        if (last_digit) begin
          if (!op_q) begin
            c_out_d = cell_carry;
            state_d = DONE;
          end else if (cell_carry) begin
            neg_d   = 1'b0;
            state_d = DONE;
          end else begin
            // No borrow-free carry out: x < y, so complement the digits.
            neg_d   = 1'b1;
            carry_d = 1'b1;
            cnt_d   = CW'(N_DIGITS);
            state_d = COMP;
          end
        end
      end

      COMP: begin
        z_d     = z_shift;
        carry_d = cell_carry;
        cnt_d   = cnt_q - CW'(1);
        if (last_digit) state_d = DONE;
      end

      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_out_q <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      c_out_q <= c_out_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign z     = z_q;
  assign c_out = c_out_q;
  assign neg   = neg_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Directed bench for bcd_serial_addsub (N_DIGITS=4): results, latency,
// handshake, restart-while-busy and async reset abort.
module tb_bcd_serial_addsub;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic        op;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [15:0] z;
  logic        c_out;
  logic        neg;
  logic        err;

  int checks = 0;
  int errors = 0;

  bcd_serial_addsub #(.N_DIGITS(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .start (start),
    .op    (op),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .c_out (c_out),
    .neg   (neg),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and observe it: lat is the number of edges after the
  // capture edge at which done is first seen (-1 if never within budget).
  task automatic do_op(input logic [15:0] xa, input logic [15:0] ya, input logic o,
                       input int restart_edge, output int lat,
                       output logic [15:0] zr, output logic cr, output logic nr,
                       output logic er, output bit busy_ok, output bit hold_ok,
                       output int extra_done);
    @(negedge clk);
    x = xa; y = ya; op = o; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x = 16'h8765; y = 16'h4321; op = ~o;
    lat = -1; busy_ok = 1'b1; hold_ok = 1'b1; extra_done = 0;
    zr = 'x; cr = 'x; nr = 'x; er = 'x;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (k == restart_edge) begin
        start = 1'b1; x = 16'h1111; y = 16'h1111; op = 1'b0;
      end
      @(posedge clk); #1;
      if (k == restart_edge) start = 1'b0;
      if (done === 1'b1) begin
        lat = k; zr = z; cr = c_out; nr = neg; er = err;
        if (busy !== 1'b0) busy_ok = 1'b0;
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra_done++;
      if (z !== zr || c_out !== cr || neg !== nr || err !== er || busy !== 1'b0)
        hold_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b0; op = 1'b0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, z, c_out, neg, err} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b z=%h c=%b n=%b e=%b want all 0",
               busy, done, z, c_out, neg, err);
    end
    @(negedge clk); rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  // One directed vector: expected z/c/n/e/latency are hand-computed constants.
  task automatic test_vector(input string name, input logic [15:0] xa, input logic [15:0] ya,
                             input logic o, input logic [15:0] ez, input logic ec,
                             input logic en, input logic ee, input int elat);
    int lat, extra; logic [15:0] zr; logic cr, nr, er; bit bok, hok;
    do_op(xa, ya, o, 0, lat, zr, cr, nr, er, bok, hok, extra);
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if (zr !== ez || cr !== ec || nr !== en || er !== ee) begin
      errors++;
      $display("FAIL %s_result got z=%h c=%b n=%b e=%b want z=%h c=%b n=%b e=%b",
               name, zr, cr, nr, er, ez, ec, en, ee);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL %s_busy got wrong busy level during op want 1 until done then 0", name);
    end
    checks++;
    if (!hok || extra != 0) begin
      errors++;
      $display("FAIL %s_hold got hold_ok=%0d extra_done=%0d want 1 0", name, hok, extra);
    end
  endtask

  task automatic test_add();
    test_vector("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    test_vector("add_0_0",       16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_overflow();
    test_vector("ovf_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    test_vector("ovf_5555_4445", 16'h5555, 16'h4445, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    test_vector("ovf_9999_9999", 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 1'b0, 5);
  endtask

  task automatic test_sub();
    test_vector("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 16'h3766, 1'b0, 1'b0, 1'b0, 5);
    test_vector("sub_0042_0042", 16'h0042, 16'h0042, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
    test_vector("sub_1234_5000", 16'h1234, 16'h5000, 1'b1, 16'h3766, 1'b0, 1'b1, 1'b0, 9);
    test_vector("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 9);
    test_vector("sub_0100_9999", 16'h0100, 16'h9999, 1'b1, 16'h9899, 1'b0, 1'b1, 1'b0, 9);
  endtask

  task automatic test_err();
    test_vector("err_x_12A4", 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    test_vector("err_y_F000", 16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    // err must clear on the next valid operation
    test_vector("after_err",  16'h0010, 16'h0005, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 5);
  endtask

  task automatic test_restart_ignored();
    int lat, extra; logic [15:0] zr; logic cr, nr, er; bit bok, hok;
    do_op(16'h1234, 16'h5678, 1'b0, 2, lat, zr, cr, nr, er, bok, hok, extra);
    checks++;
    if (lat != 5 || zr !== 16'h6912 || cr !== 1'b0) begin
      errors++;
      $display("FAIL restart_result got lat=%0d z=%h c=%b want 5 6912 0", lat, zr, cr);
    end
    checks++;
    if (extra != 0 || !hok) begin
      errors++;
      $display("FAIL restart_single_done got extra_done=%0d hold_ok=%0d want 0 1", extra, hok);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen_done;
    int lat, extra; logic [15:0] zr; logic cr, nr, er; bit bok, hok;
    @(negedge clk);
    x = 16'h1234; y = 16'h5678; op = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run_busy got %b want 1", busy);
    end
    rst_b = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || z !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset_clear got busy=%b done=%b z=%h want 0 0 0000", busy, done, z);
    end
    @(negedge clk); rst_b = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d active cycles want 0", seen_done);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 0, lat, zr, cr, nr, er, bok, hok, extra);
    checks++;
    if (lat != 5 || zr !== 16'h0003 || cr !== 1'b0 || nr !== 1'b0 || er !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_add got lat=%0d z=%h c=%b n=%b e=%b want 5 0003 0 0 0",
               lat, zr, cr, nr, er);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_sub();
    test_err();
    test_restart_ignored();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_addsub.md
Name: bcd_serial_addsub

Overview:
- Digit-serial, multi-digit BCD adder/subtractor.
- Processes one BCD digit per clock, LSD first, using a start/busy/done handshake.
- Supports add and subtract. Subtract returns a signed-magnitude result, so a negative difference comes back as a magnitude plus a sign flag.
- Successor to the combinational ripple BCD adder. Used where a wide BCD operation must share a single digit cell over several cycles.

Parameters:
- N_DIGITS, 4, number of BCD digits per operand (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous reset, active-low.
- start  in  1  request. Sampled only in IDLE.
- op  in  1  0 = add (x+y), 1 = subtract (x-y). Sampled with start.
- x  in  4*N_DIGITS  operand A, packed BCD, digit i at [4i+3:4i].
- y  in  4*N_DIGITS  operand B, packed BCD.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; z/c_out/neg/err valid from this cycle.
- z  out  4*N_DIGITS  result (sum, or magnitude of difference).
- c_out  out  1  add: decimal carry out of MSD. Subtract: always 0.
- neg  out  1  subtract: 1 if x<y. Add: always 0.
- err  out  1  1 if any operand digit >9 at start.

Behaviour:
- Reset (rst_b=0, async): state=IDLE. busy, done, z, c_out, neg, err and all internal registers go to 0. Reset mid-operation aborts; no done is produced.
- Operand capture: start=1 in IDLE latches x, y and op into internal shift registers at edge E0. Inputs may change afterwards.
- start while busy or in DONE is ignored; it is not queued.
- States: IDLE, CHECK-free RUN, COMP, DONE.
- Validity check at E0, combinational on x/y:
  - If any digit >9: go to DONE at E0. err=1, z=0, c_out=0, neg=0, done at E1.
- RUN (edges E1..E_N): edge k processes digit k-1.
  - yd = y digit (add) or 9 - y digit (subtract).
  - Initial carry cin = op.
  - s = xd + yd + cin (5-bit). If s>9: digit = s+6 (low 4 bits), carry=1. Else digit = s, carry=0.
  - The digit shifts into z from the MSD side, so z is fully aligned after N edges.
  - Intermediate z values during busy are don't-care.
- End of RUN at E_N, using the final carry:
  - add: c_out = carry, go to DONE.
  - sub with carry=1: result is non-negative. neg=0, go to DONE.
  - sub with carry=0: result is negative. neg=1, go to COMP.
- COMP (edges E_{N+1}..E_{2N}): ten's complement of z, digit-serial.
  - Per digit: t = (9 - zd) + cin, with cin=1 initially.
  - If t=10: digit 0, carry=1. Else digit t, carry=0.
  - At E_{2N}, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0. Next edge returns to IDLE.
- A start present in the DONE cycle is ignored; it must be held or reissued in IDLE.
- Latency from the start-capture edge E0 to done:
  - valid add, or subtract with x>=y: done high after edge E_{N+1}, i.e. N+1 edges.
  - subtract with x<y: 2N+1 edges.
  - err: 1 edge.
- Result registers hold their values from done until the next accepted start.
- Wrap-around: an add overflow is reported only through c_out; z holds the low N digits.
- Zero difference: x=y under subtract gives z=0, neg=0 (never negative zero).
- Registers: shift registers for operands, a digit counter sized ceil(log2(N_DIGITS+1)), and a carry flop. One shared digit cell serves RUN and COMP.

Test Plan (N_DIGITS=4, z shown as packed hex):
- Add: x=1234, y=5678, op=0, start at E0 -> done after E5, z=6912, c_out=0, neg=0, err=0; busy high E1..E4.
- Add overflow: x=9999, y=0001 -> z=0000, c_out=1 after E5. Also x=5555, y=4445 -> z=0000, c_out=1.
- Subtract, non-negative: x=5000, y=1234, op=1 -> z=3766, neg=0 after E5. Also x=0042, y=0042 -> z=0000, neg=0.
- Subtract, negative: x=1234, y=5000, op=1 -> z=3766, neg=1, done after E9. Also x=0000, y=0001 -> z=0001, neg=1.
- Error and handshake:
  - x=12A4 -> err=1, z=0000, done after E1.
  - start pulsed again at E2 during a run -> ignored; only one done, with the original result.
- Reset: rst_b low mid-RUN (after E2), asynchronously -> busy/done/z cleared immediately, no done. A following add 0001+0002 -> z=0003.
